// File: rtl/pr_handshake_pkg.sv
// pr_handshake_pkg: shared state encoding, default parameters and counter sizing for the PR handshake controller
package pr_handshake_pkg;
  typedef enum logic [2:0] {
    RUN     = 3'd0,
    DRAIN   = 3'd1,
    FROZEN  = 3'd2,
    RESET   = 3'd3,
    STARTED = 3'd4
  } state_e;
  localparam int DEF_NUM_REGIONS    = 4;
  localparam int DEF_TIMEOUT_CYCLES = 1024;
  localparam int DEF_RESET_CYCLES   = 16;
  function automatic int cnt_width(input int t, input int r);
    return $clog2((t > r ? t : r) + 1);
  endfunction
endpackage

// File: rtl/pr_handshake_chan.sv
// pr_handshake_chan: one region's stop/drain/freeze/reset/start sequencer with drain timeout and sticky flag
module pr_handshake_chan
  import pr_handshake_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int RESET_CYCLES   = DEF_RESET_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic stop_req_i,
  input  logic start_req_i,
  input  logic persona_idle_i,
  input  logic timeout_clr_i,
  output logic stop_ack_o,
  output logic start_ack_o,
  output logic persona_freeze_o,
  output logic persona_reset_o,
  output logic region_active_o,
  output logic timeout_flag_o
);
  localparam int CNT_W = cnt_width(TIMEOUT_CYCLES, RESET_CYCLES);
  localparam logic [CNT_W-1:0] T_LAST = CNT_W'(TIMEOUT_CYCLES > 0 ? TIMEOUT_CYCLES - 1 : 0);
  localparam logic [CNT_W-1:0] R_LAST = CNT_W'(RESET_CYCLES - 1);
  state_e state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic flag_q, flag_d, set_to;
  logic stop_ack_q, start_ack_q, freeze_q, preset_q, active_q;
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    set_to  = 1'b0;
    case (state_q)
      RUN: begin
        state_d = stop_req_i ? DRAIN : start_req_i ? RESET : RUN;
        cnt_d   = (stop_req_i || start_req_i) ? '0 : cnt_q;
      end
      DRAIN: begin
        if (!stop_req_i) state_d = RUN;
        else if (persona_idle_i) state_d = FROZEN;
        else if (TIMEOUT_CYCLES > 0 && cnt_q == T_LAST) begin
          state_d = FROZEN;
          set_to  = 1'b1;
        end else cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
      end
      FROZEN: begin
        state_d = (start_req_i && !stop_req_i) ? RESET : FROZEN;
        cnt_d   = (start_req_i && !stop_req_i) ? '0 : cnt_q;
      end
      RESET: begin
        state_d = (cnt_q == R_LAST) ? STARTED : RESET;
        cnt_d   = (cnt_q == R_LAST || cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
      end
      STARTED: state_d = start_req_i ? STARTED : RUN;
      default: begin
        state_d = RUN;
        cnt_d   = '0;
      end
    endcase
    flag_d = set_to | (flag_q & ~timeout_clr_i);
  end
  // Outputs are registered from the next state so they change together with it
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= RUN;
      cnt_q       <= '0;
      flag_q      <= 1'b0;
      stop_ack_q  <= 1'b0;
      start_ack_q <= 1'b0;
      freeze_q    <= 1'b0;
      preset_q    <= 1'b0;
      active_q    <= 1'b1;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      flag_q      <= flag_d;
      stop_ack_q  <= (state_d == FROZEN) && stop_req_i;
      start_ack_q <= state_d == STARTED;
      freeze_q    <= (state_d == DRAIN) || (state_d == FROZEN) || (state_d == RESET);
      preset_q    <= state_d == RESET;
      active_q    <= state_d == RUN;
    end
  end
  assign stop_ack_o       = stop_ack_q;
  assign start_ack_o      = start_ack_q;
  assign persona_freeze_o = freeze_q;
  assign persona_reset_o  = preset_q;
  assign region_active_o  = active_q;
  assign timeout_flag_o   = flag_q;
endmodule

// File: rtl/pr_region_handshake_ctrl.sv
// pr_region_handshake_ctrl: array of independent per-region freeze/start handshake channels
module pr_region_handshake_ctrl
  import pr_handshake_pkg::*;
#(
  parameter int NUM_REGIONS    = DEF_NUM_REGIONS,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int RESET_CYCLES   = DEF_RESET_CYCLES
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_REGIONS-1:0] stop_req,
  output logic [NUM_REGIONS-1:0] stop_ack,
  input  logic [NUM_REGIONS-1:0] start_req,
  output logic [NUM_REGIONS-1:0] start_ack,
  input  logic [NUM_REGIONS-1:0] persona_idle,
  output logic [NUM_REGIONS-1:0] persona_freeze,
  output logic [NUM_REGIONS-1:0] persona_reset,
  output logic [NUM_REGIONS-1:0] region_active,
  output logic [NUM_REGIONS-1:0] timeout_flag,
  input  logic [NUM_REGIONS-1:0] timeout_clr
);
  for (genvar i = 0; i < NUM_REGIONS; i++) begin : g_chan
    pr_handshake_chan #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
      .RESET_CYCLES  (RESET_CYCLES)
    ) u_chan (
      .clk             (clk),
      .rst             (reset),
      .stop_req_i      (stop_req[i]),
      .start_req_i     (start_req[i]),
      .persona_idle_i  (persona_idle[i]),
      .timeout_clr_i   (timeout_clr[i]),
      .stop_ack_o      (stop_ack[i]),
      .start_ack_o     (start_ack[i]),
      .persona_freeze_o(persona_freeze[i]),
      .persona_reset_o (persona_reset[i]),
      .region_active_o (region_active[i]),
      .timeout_flag_o  (timeout_flag[i])
    );
  end
endmodule
